// File: rtl/gear_input_pkg.sv
// Shared timing defaults and arbitration types for the gearbox input conditioner.
package gear_input_pkg;

    localparam int DEBOUNCE_CYCLES_25K = 250;   // 10 ms at 25 kHz
    localparam int HOLDOFF_CYCLES_25K  = 2500;  // 100 ms at 25 kHz
    localparam int CNT_W               = 12;

    // Outcome of one cycle of shift arbitration.
    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_UP,
        ARB_DOWN,
        ARB_CONFLICT
    } arb_e;

endpackage

// File: rtl/gear_input_conditioner_debounce.sv
// One button channel: two-flop synchroniser followed by a consecutive-cycle
// debounce filter that flips the stable value only after a sustained change.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = gear_input_pkg::DEBOUNCE_CYCLES_25K,
    parameter int CNT_W           = gear_input_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;  // sync_q[1] is the synchronised input
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gear_input_conditioner.sv
// Gearbox front end: debounces the three buttons and turns shift presses into
// arbitrated, holdoff-limited single-cycle requests plus a clean brake level.
module gear_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = gear_input_pkg::DEBOUNCE_CYCLES_25K,
    parameter int HOLDOFF_CYCLES  = gear_input_pkg::HOLDOFF_CYCLES_25K,
    parameter int CNT_W           = gear_input_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_brake_raw,
    output logic shift_up_pulse,
    output logic shift_down_pulse,
    output logic brake_level,
    output logic conflict_pulse
);

    import gear_input_pkg::*;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > (1 << CNT_W)) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be >= 1 and HOLDOFF_CYCLES-1 must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    logic             stable_up;
    logic             stable_down;
    logic             stable_brake;
    logic             up_d;
    logic             down_d;
    logic             rise_up;
    logic             rise_down;
    logic [CNT_W-1:0] holdoff;
    arb_e             arb;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_up_raw),
        .stable (stable_up)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_down_raw),
        .stable (stable_down)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_brake (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_brake_raw),
        .stable (stable_brake)
    );

    assign rise_up     = stable_up & ~up_d;
    assign rise_down   = stable_down & ~down_d;
    assign brake_level = stable_brake;

    // Priority: enable, then simultaneous conflict, then holdoff, then brake
    // interlock on upshift. Rises that lose are dropped, never queued.
    // NOTE: arb gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        arb = ARB_NONE;
        if (ena) begin
            if (rise_up && rise_down) begin
                arb = ARB_CONFLICT;
            end else if (holdoff != '0) begin
                arb = ARB_NONE;
            end else if (rise_up) begin
                arb = stable_brake ? ARB_NONE : ARB_UP;
            end else if (rise_down) begin
                arb = ARB_DOWN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_d             <= 1'b0;
            down_d           <= 1'b0;
            holdoff          <= '0;
            shift_up_pulse   <= 1'b0;
            shift_down_pulse <= 1'b0;
            conflict_pulse   <= 1'b0;
        end else begin
            up_d             <= stable_up;
            down_d           <= stable_down;
            shift_up_pulse   <= (arb == ARB_UP);
            shift_down_pulse <= (arb == ARB_DOWN);
            conflict_pulse   <= (arb == ARB_CONFLICT);
            if (arb == ARB_UP || arb == ARB_DOWN) begin
                holdoff <= HOLD_LAST;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gear_input_conditioner.sv
// Scoreboard bench for gear_input_conditioner: a cycle-indexed behavioural
// model predicts pulses, a monitor pops and compares them as the DUT emits.
module tb_gear_input_conditioner;

    localparam int D     = 4;
    localparam int H     = 8;
    localparam int LOG_N = 16384;

    logic clk           = 1'b0;
    logic rst_n         = 1'b0;
    logic ena           = 1'b1;
    logic btn_up_raw    = 1'b0;
    logic btn_down_raw  = 1'b0;
    logic btn_brake_raw = 1'b0;
    logic shift_up_pulse;
    logic shift_down_pulse;
    logic brake_level;
    logic conflict_pulse;

    gear_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLDOFF_CYCLES  (H),
        .CNT_W           (12)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ena              (ena),
        .btn_up_raw       (btn_up_raw),
        .btn_down_raw     (btn_down_raw),
        .btn_brake_raw    (btn_brake_raw),
        .shift_up_pulse   (shift_up_pulse),
        .shift_down_pulse (shift_down_pulse),
        .brake_level      (brake_level),
        .conflict_pulse   (conflict_pulse)
    );

    always #5 clk = ~clk;

    // kind: 1 = shift up, 2 = shift down, 3 = conflict
    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rst_mark = 0;
    int   last_pulse;
    int   st[3];
    int   prev[3];
    bit   raw_log[3][LOG_N];
    int   n_up = 0;
    int   n_down = 0;
    int   n_conf = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            st[ch]   = 0;
            prev[ch] = 0;
        end
        last_pulse = -1000000;
    endtask

    // A synchronised sample at edge k is the raw value captured two edges
    // earlier, or 0 if that capture happened before reset was released.
    function automatic int sync_at(input int ch, input int k);
        if (k - 2 > rst_mark) return int'(raw_log[ch][k-2]);
        return 0;
    endfunction

    task automatic model_step();
        int n;
        int kind;
        bit ru;
        bit rd;
        bit all_differ;
        n = cyc;
        if (n < LOG_N) begin
            raw_log[0][n] = btn_up_raw;
            raw_log[1][n] = btn_down_raw;
            raw_log[2][n] = btn_brake_raw;
        end
        ru   = (st[0] == 1) && (prev[0] == 0);
        rd   = (st[1] == 1) && (prev[1] == 0);
        kind = 0;
        if (ena) begin
            if (ru && rd)                kind = 3;
            else if (n - last_pulse < H) kind = 0;
            else if (ru)                 kind = (st[2] == 1) ? 0 : 1;
            else if (rd)                 kind = 2;
        end
        if (kind == 1 || kind == 2) last_pulse = n;
        if (kind != 0) sb.push_back('{kind, n});
        // Stable value flips once the last D synchronised samples all disagree.
        for (int ch = 0; ch < 3; ch++) begin
            prev[ch]   = st[ch];
            all_differ = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (sync_at(ch, n - j) == st[ch]) all_differ = 1'b0;
            end
            if (all_differ) st[ch] = 1 - st[ch];
        end
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) cyc++;
            if (!rst_n) begin
                rst_mark = cyc;
                model_reset();
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int   dk;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    check("missed_pulse", 0, sb[0].kind);
                    void'(sb.pop_front());
                end
                check("brake_level", int'(brake_level), st[2]);
                check("up_down_exclusive", int'(shift_up_pulse & shift_down_pulse), 0);
                if (shift_up_pulse || shift_down_pulse || conflict_pulse) begin
                    dk = shift_up_pulse ? 1 : (shift_down_pulse ? 2 : 3);
                    if (dk == 1) n_up++;
                    if (dk == 2) n_down++;
                    if (dk == 3) n_conf++;
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", dk, 0);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_kind", dk, e.kind);
                        check("pulse_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit pulse_of(input int which);
        case (which)
            1:       return shift_up_pulse;
            2:       return shift_down_pulse;
            default: return conflict_pulse;
        endcase
    endfunction

    // Waits (bounded) for a pulse and checks its distance from cycle c0.
    task automatic wait_pulse(input int which, input int c0, input string name, input int exp_lat);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pulse_of(which) && k < 20);
        check(name, cyc - c0, exp_lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int c0;
        int u0, d0, f0;
        int hold[3];
        bit lvl[3];

        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Clean press: pulse 2 sync + D debounce + 1 register cycles later.
        u0 = n_up;
        c0 = cyc;
        btn_up_raw = 1'b1;
        wait_pulse(1, c0, "clean_latency", 2 + D + 1);
        tick(20);
        check("clean_single_pulse", n_up - u0, 1);
        btn_up_raw = 1'b0;
        tick(20);

        // Bounce: 2-cycle toggles are filtered, one pulse after the final hold.
        d0 = n_down;
        for (int i = 0; i < 12; i++) begin
            btn_down_raw = ((i / 2) % 2 == 0);
            tick(1);
        end
        c0 = cyc;
        btn_down_raw = 1'b1;
        wait_pulse(2, c0, "bounce_latency", 2 + D + 1);
        tick(20);
        check("bounce_single_pulse", n_down - d0, 1);
        btn_down_raw = 1'b0;
        tick(20);

        // Holdoff: up pulse at c0+7, down rise at c0+12 dropped, up re-rise at c0+17 accepted.
        u0 = n_up;
        d0 = n_down;
        c0 = cyc;
        btn_up_raw = 1'b1;
        tick(4);
        btn_up_raw = 1'b0;
        tick(1);
        btn_down_raw = 1'b1;
        tick(5);
        btn_up_raw = 1'b1;
        tick(25);
        check("holdoff_up_count", n_up - u0, 2);
        check("holdoff_down_dropped", n_down - d0, 0);
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        tick(20);

        // Brake interlock.
        btn_brake_raw = 1'b1;
        tick(2 + D - 1);
        check("brake_before_latency", int'(brake_level), 0);
        tick(1);
        check("brake_at_latency", int'(brake_level), 1);
        u0 = n_up;
        d0 = n_down;
        btn_up_raw = 1'b1;
        tick(20);
        check("brake_blocks_up", n_up - u0, 0);
        btn_up_raw = 1'b0;
        tick(20);
        btn_down_raw = 1'b1;
        tick(20);
        check("brake_allows_down", n_down - d0, 1);
        btn_down_raw  = 1'b0;
        btn_brake_raw = 1'b0;
        tick(20);

        // Simultaneous rise: conflict only, then the next press is accepted.
        u0 = n_up;
        d0 = n_down;
        f0 = n_conf;
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        tick(15);
        check("conflict_pulse_count", n_conf - f0, 1);
        check("conflict_no_up", n_up - u0, 0);
        check("conflict_no_down", n_down - d0, 0);
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        tick(D + 3);
        btn_up_raw = 1'b1;
        tick(20);
        check("after_conflict_up", n_up - u0, 1);
        btn_up_raw = 1'b0;
        tick(20);

        // Asynchronous reset while brake is high and an up press is mid-debounce.
        btn_brake_raw = 1'b1;
        tick(10);
        btn_up_raw = 1'b1;
        tick(3);
        #2;
        rst_n         = 1'b0;
        btn_brake_raw = 1'b0;
        #1;
        check("reset_brake_level", int'(brake_level), 0);
        check("reset_up_pulse", int'(shift_up_pulse), 0);
        check("reset_down_pulse", int'(shift_down_pulse), 0);
        check("reset_conflict", int'(conflict_pulse), 0);
        tick(2);
        rst_n = 1'b1;
        u0 = n_up;
        tick(20);
        check("held_after_reset_is_new_press", n_up - u0, 1);
        btn_up_raw = 1'b0;
        tick(20);

        // ena low drops rises; raising ena while held does not replay them.
        d0  = n_down;
        ena = 1'b0;
        btn_down_raw = 1'b1;
        tick(20);
        check("ena_low_no_pulse", n_down - d0, 0);
        ena = 1'b1;
        tick(20);
        check("ena_raise_while_held", n_down - d0, 0);
        btn_down_raw = 1'b0;
        tick(20);

        // Randomised traffic against the model.
        for (int ch = 0; ch < 3; ch++) begin
            hold[ch] = 0;
            lvl[ch]  = 1'b0;
        end
        for (int t = 0; t < 3000; t++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = !lvl[ch];
                    hold[ch] = (ch == 2) ? int'($urandom_range(3, 40)) : int'($urandom_range(1, 16));
                end
                hold[ch]--;
            end
            btn_up_raw    = lvl[0];
            btn_down_raw  = lvl[1];
            btn_brake_raw = lvl[2];
            if ($urandom_range(0, 199) == 0) ena = !ena;
            if (t == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_reset_brake", int'(brake_level), 0);
                check("rand_reset_up", int'(shift_up_pulse), 0);
            end
            if (t == 1502) rst_n = 1'b1;
            @(negedge clk);
        end

        ena           = 1'b1;
        btn_up_raw    = 1'b0;
        btn_down_raw  = 1'b0;
        btn_brake_raw = 1'b0;
        tick(40);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
